// File: rtl/maj_tt_pkg.sv
// Shared definitions for the majority truth-table sweepers.
//   state_t    : sweeper FSM states
//   N_MINTERM  : number of minterms of the 7-input network
//   maj3       : 3-input majority, ab | ac | bc
package maj_tt_pkg;

  localparam int unsigned N_MINTERM = 128;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT,
    FINISH
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/maj_net7.sv
// Purely combinational 7-input majority-of-three network.
//   x : minterm inputs, x[i] = bit i of the minterm index
//   f : network output
import maj_tt_pkg::*;

module maj_net7 (
  input  logic [6:0] x,
  output logic       f
);

  logic w0;
  logic w1;
  logic w2;
  logic w3;

  always_comb begin
    w0 = maj3(x[0], x[2], x[4]);
    w1 = maj3(x[2], x[6], w0);
    w2 = maj3(x[0], x[1], x[5]);
    w3 = maj3(x[3], w1, w2);
    f  = maj3(x[1], w0, w3);
  end

endmodule

// File: rtl/maj_tt_sweeper.sv
// Drives maj_net7 through all 128 minterms, packs the results into OUT_W-bit
// truth-table chunks and streams them out over valid/ready, then reports the
// onset count.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : begins a sweep when sampled in IDLE
//   busy       : sweep in progress (FILL/EMIT)
//   tt_data    : current chunk, bit j = f(chunk_base + j)
//   tt_valid   : chunk available
//   tt_ready   : consumer accepts chunk when tt_valid && tt_ready
//   done       : one-cycle pulse after the last chunk is accepted
//   ones_count : popcount of the full table, stable from done until next start
//   self_dual  : (MAJ_TT_SELFDUAL_EN only) table satisfies f(~x) == ~f(x)
// Optional feature macro: MAJ_TT_SELFDUAL_EN
import maj_tt_pkg::*;

module maj_tt_sweeper #(
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [OUT_W-1:0] tt_data,
  output logic             tt_valid,
  input  logic             tt_ready,
  output logic             done,
  output logic [7:0]       ones_count
`ifdef MAJ_TT_SELFDUAL_EN
  ,
  output logic             self_dual
`endif
);

  localparam int unsigned N_CHUNK = N_MINTERM / OUT_W;
  localparam int unsigned IW      = $clog2(OUT_W);

  if ((N_CHUNK * OUT_W != N_MINTERM) || (OUT_W < 8)) begin : g_bad_out_w
    $error("maj_tt_sweeper: OUT_W must be one of 8, 16, 32, 64, 128");
  end

  state_t           state;
  state_t           state_next;
  logic [6:0]       m;
  logic             f;
  logic [OUT_W-1:0] chunk_reg;
  logic [OUT_W-1:0] chunk_next;
  logic [IW-1:0]    idx;
  logic             last_bit;

  maj_net7 u_net (
    .x (m),
    .f (f)
  );

  // Position of the current minterm inside its chunk.
  assign idx      = m[IW-1:0];
  assign last_bit = (idx == IW'(OUT_W - 1));

  // Chunk with the current result merged in, so the completed chunk can be
  // published on the same edge that writes its final bit.
  always_comb begin
    chunk_next      = chunk_reg;
    chunk_next[idx] = f;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Completion is flagged by m having wrapped to 0.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FILL;
      FILL:    if (last_bit) state_next = EMIT;
      EMIT:    if (tt_ready) state_next = (m == 7'd0) ? FINISH : FILL;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = 1'b0;
    tt_valid = 1'b0;
    done     = 1'b0;
    case (state)
      FILL:    busy = 1'b1;
      EMIT: begin
        busy     = 1'b1;
        tt_valid = 1'b1;
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: minterm counter, chunk assembly, onset count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m          <= '0;
      chunk_reg  <= '0;
      tt_data    <= '0;
      ones_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m          <= '0;
            ones_count <= '0;
          end
        end
        FILL: begin
          chunk_reg  <= chunk_next;
          ones_count <= ones_count + {7'd0, f};
          m          <= m + 7'd1;
          if (last_bit) begin
            tt_data <= chunk_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAJ_TT_SELFDUAL_EN
  logic [N_MINTERM-1:0] tt_full;
  logic                 sd_calc;

  // Self-dual: every minterm differs from its complement minterm.
  always_comb begin
    sd_calc = 1'b1;
    for (int unsigned i = 0; i < N_MINTERM; i++) begin
      int unsigned j;
      j       = N_MINTERM - 1 - i;
      sd_calc = sd_calc & (tt_full[i[6:0]] != tt_full[j[6:0]]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_full   <= '0;
      self_dual <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (start) self_dual <= 1'b0;
        FILL:    tt_full[m] <= f;
        FINISH:  self_dual <= sd_calc;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_maj_tt_sweeper.sv
module tb_maj_tt_sweeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // OUT_W = 16 instance
  logic        start16, ready16, busy16, valid16, done16;
  logic [15:0] data16;
  logic [7:0]  ones16;
  // OUT_W = 8 instance
  logic        start8, ready8, busy8, valid8, done8;
  logic [7:0]  data8;
  logic [7:0]  ones8;
  // OUT_W = 128 instance
  logic         start128, ready128, busy128, valid128, done128;
  logic [127:0] data128;
  logic [7:0]   ones128;
`ifdef MAJ_TT_SELFDUAL_EN
  logic sd16, sd8, sd128;
`endif

  maj_tt_sweeper #(.OUT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .busy(busy16), .tt_data(data16),
    .tt_valid(valid16), .tt_ready(ready16), .done(done16), .ones_count(ones16)
`ifdef MAJ_TT_SELFDUAL_EN
    , .self_dual(sd16)
`endif
  );

  maj_tt_sweeper #(.OUT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .tt_data(data8),
    .tt_valid(valid8), .tt_ready(ready8), .done(done8), .ones_count(ones8)
`ifdef MAJ_TT_SELFDUAL_EN
    , .self_dual(sd8)
`endif
  );

  maj_tt_sweeper #(.OUT_W(128)) u_dut128 (
    .clk(clk), .rst(rst), .start(start128), .busy(busy128), .tt_data(data128),
    .tt_valid(valid128), .tt_ready(ready128), .done(done128), .ones_count(ones128)
`ifdef MAJ_TT_SELFDUAL_EN
    , .self_dual(sd128)
`endif
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Independent reference of the network.
  function automatic logic ref_f(input logic [6:0] x);
    logic w0, w1, w2, w3;
    w0 = (x[0] & x[2]) | (x[0] & x[4]) | (x[2] & x[4]);
    w1 = (x[2] & x[6]) | (x[2] & w0) | (x[6] & w0);
    w2 = (x[0] & x[1]) | (x[0] & x[5]) | (x[1] & x[5]);
    w3 = (x[3] & w1) | (x[3] & w2) | (w1 & w2);
    return (x[1] & w0) | (x[1] & w3) | (w0 & w3);
  endfunction

  function automatic logic [15:0] ref_chunk16(input int unsigned k);
    logic [15:0] c;
    for (int unsigned j = 0; j < 16; j++) c[j] = ref_f(7'(k * 16 + j));
    return c;
  endfunction

  typedef struct {
    int unsigned idx;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  logic [15:0] got16[8];
  int unsigned nch16, done_cyc, ndone, first_valid;
  logic        sd_at_start;

  // One OUT_W=16 sweep. stall = cycles tt_ready is held low at each EMIT;
  // poke = also pulse start during FILL and during the done cycle.
  task automatic sweep16(input int unsigned stall, input bit poke);
    int unsigned hold;
    logic [15:0] held;
    nch16 = 0; ndone = 0; done_cyc = 0; first_valid = 0; hold = 0; held = '0;
    sd_at_start = 1'b0;
    @(negedge clk);
    start16 = 1'b1;
    ready16 = (stall == 0);
    @(negedge clk);
    start16 = 1'b0;
`ifdef MAJ_TT_SELFDUAL_EN
    sd_at_start = sd16;
`endif
    for (int unsigned cyc = 1; cyc < 600; cyc++) begin
      start16 = 1'b0;
      if (poke && (cyc == 5 || done16)) start16 = 1'b1;
      if (done16) begin
        ndone++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (valid16) begin
        if (first_valid == 0) first_valid = cyc;
        if (hold == 0) held = data16;
        else check("hold_data", 128'(data16), 128'(held));
        if (hold >= stall) begin
          ready16 = 1'b1;
          if (nch16 < 8) got16[nch16] = data16;
          nch16++;
          hold = 0;
        end else begin
          ready16 = 1'b0;
          hold++;
        end
      end else begin
        if (hold != 0) begin
          check("valid_drop", 128'(valid16), 128'(1));
          hold = 0;
        end
        ready16 = (stall == 0);
      end
      if (done_cyc != 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    start16 = 1'b0;
  endtask

  task automatic check_sweep(input string tag, input int unsigned exp_done);
    check({tag, "_nchunks"}, 128'(nch16), 128'(8));
    for (int i = 0; i < 8; i++)
      check({tag, "_chunk"}, 128'(got16[vecs[i].idx]), 128'(vecs[i].exp));
    check({tag, "_first_valid"}, 128'(first_valid), 128'(17));
    check({tag, "_done_cycle"}, 128'(done_cyc), 128'(exp_done));
    check({tag, "_done_pulses"}, 128'(ndone), 128'(1));
    check({tag, "_ones"}, 128'(ones16), 128'(64));
    check({tag, "_busy_idle"}, 128'(busy16), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nch, n8, n128, d8, d128, last8, last128;
    logic [7:0]   c8[2];
    logic [127:0] g128, exp_tt;
    logic         saw_valid;

    vecs[0] = '{0, 16'hA880};
    vecs[7] = '{7, 16'hFEEA};
    for (int unsigned i = 1; i < 7; i++) vecs[i] = '{i, ref_chunk16(i)};

    rst = 1'b1;
    start16 = 0; ready16 = 0; start8 = 0; ready8 = 1; start128 = 0; ready128 = 1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 128'(busy16), 128'(0));
    check("rst_valid", 128'(valid16), 128'(0));
    check("rst_data", 128'(data16), 128'(0));
    check("rst_done", 128'(done16), 128'(0));
    check("rst_ones", 128'(ones16), 128'(0));
`ifdef MAJ_TT_SELFDUAL_EN
    check("rst_self_dual", 128'(sd16), 128'(0));
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sweep, tt_ready high
    sweep16(0, 1'b0);
    check_sweep("basic", 137);
`ifdef MAJ_TT_SELFDUAL_EN
    check("self_dual_set", 128'(sd16), 128'(1));
`endif
    repeat (10) @(negedge clk);
    check("ones_held", 128'(ones16), 128'(64));

    // Backpressure: 5 stall cycles per chunk
    sweep16(5, 1'b0);
    check_sweep("bp", 177);
`ifdef MAJ_TT_SELFDUAL_EN
    check("self_dual_cleared", 128'(sd_at_start), 128'(0));
    check("self_dual_again", 128'(sd16), 128'(1));
`endif

    // Start pulses while busy and in FINISH are ignored
    sweep16(0, 1'b1);
    check_sweep("poke", 137);
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (valid16 || busy16 || done16) saw_valid = 1'b1;
    end
    check("poke_no_restart", 128'(saw_valid), 128'(0));

    // Reset during chunk 3 EMIT
    @(negedge clk);
    start16 = 1'b1; ready16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    nch = 0;
    for (int c = 0; c < 200; c++) begin
      if (valid16) begin
        if (nch == 3) break;
        nch++;
      end
      @(negedge clk);
    end
    check("mid_reached_chunk3", 128'(nch), 128'(3));
    check("mid_valid_before_rst", 128'(valid16), 128'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 128'(busy16), 128'(0));
    check("mid_rst_valid", 128'(valid16), 128'(0));
    check("mid_rst_data", 128'(data16), 128'(0));
    check("mid_rst_ones", 128'(ones16), 128'(0));
`ifdef MAJ_TT_SELFDUAL_EN
    check("mid_rst_self_dual", 128'(sd16), 128'(0));
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (valid16 || busy16 || done16) saw_valid = 1'b1;
    end
    check("mid_quiet_after_rst", 128'(saw_valid), 128'(0));
    sweep16(0, 1'b0);
    check_sweep("after_rst", 137);

    // Width sweep: OUT_W = 8 and 128, ready tied high
    exp_tt = '0;
    for (int unsigned i = 0; i < 128; i++) exp_tt[i] = ref_f(7'(i));
    n8 = 0; n128 = 0; d8 = 0; d128 = 0; last8 = 0; last128 = 0;
    c8[0] = '0; c8[1] = '0; g128 = '0;
    @(negedge clk);
    start8 = 1'b1; start128 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; start128 = 1'b0;
    for (int unsigned cyc = 1; cyc < 400; cyc++) begin
      if (valid8) begin
        if (n8 < 2) c8[n8] = data8;
        n8++;
      end
      if (valid128) begin
        g128 = data128;
        n128++;
      end
      if (done8) begin d8++; last8 = cyc; end
      if (done128) begin d128++; last128 = cyc; end
      if (last8 != 0 && last128 != 0 && cyc > last8 + 2 && cyc > last128 + 2) break;
      @(negedge clk);
    end
    check("w8_nchunks", 128'(n8), 128'(16));
    check("w8_chunk0", 128'(c8[0]), 128'h80);
    check("w8_chunk1", 128'(c8[1]), 128'hA8);
    check("w8_done", 128'(d8), 128'(1));
    check("w8_done_cycle", 128'(last8), 128'(16 * 9 + 1));
    check("w8_ones", 128'(ones8), 128'(64));
    check("w128_nchunks", 128'(n128), 128'(1));
    check("w128_table", g128, exp_tt);
    check("w128_done", 128'(d128), 128'(1));
    check("w128_done_cycle", 128'(last128), 128'(129 + 1));
    check("w128_ones", 128'(ones128), 128'(64));
`ifdef MAJ_TT_SELFDUAL_EN
    check("w8_self_dual", 128'(sd8), 128'(1));
    check("w128_self_dual", 128'(sd128), 128'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
